// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the chunked add/subtract sequencer.
// Macro ABS_MODE_EN adds the NEG state used for absolute-value results.
package addsub_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefChunk = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
`ifdef ABS_MODE_EN
        StNeg  = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/chunked_addsub_seq_if.sv
// Request/result bundle for chunked_addsub_seq; master drives requests, slave returns results.
interface chunked_addsub_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sub;
    logic             abs_req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, abs_req, a, b,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, sub, abs_req, a, b,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder shared by every datapath step.
module chunk_adder
    import addsub_pkg::*;
#(
    parameter int unsigned CHUNK = DefChunk
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/chunked_addsub_seq.sv
// Sequential add/subtract processing CHUNK bits per cycle, LSB slice first.
// Macro ABS_MODE_EN enables the NEG pass that returns |result| when abs_req is set.
module chunked_addsub_seq
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CHUNK = DefChunk
) (
    input logic                  clk,
    input logic                  rst,
    chunked_addsub_seq_if.slave  io
);
    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("chunked_addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
`ifdef ABS_MODE_EN
    logic             abs_q, abs_d;
`else
    logic             unused_abs;
    assign unused_abs = io.abs_req;
`endif

    logic [WIDTH-1:0] b_eff;
    int unsigned      lsb;
    logic [CHUNK-1:0] add_a, add_b, add_s;
    logic             add_cin, add_co;

    assign b_eff = sub_q ? ~b_q : b_q;
    assign lsb   = 32'(idx_q) * CHUNK;

    // One adder serves both passes; NEG adds ~sum + 1 slice by slice.
    always_comb begin
        add_a   = a_q[lsb +: CHUNK];
        add_b   = b_eff[lsb +: CHUNK];
        add_cin = (idx_q == '0) ? sub_q : carry_q;
`ifdef ABS_MODE_EN
        if (state_q == StNeg) begin
            add_a   = ~sum_q[lsb +: CHUNK];
            add_b   = '0;
            add_cin = (idx_q == '0) ? 1'b1 : carry_q;
        end
`endif
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef ABS_MODE_EN
        abs_d   = abs_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (io.start) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    sub_d   = io.sub;
`ifdef ABS_MODE_EN
                    abs_d   = io.abs_req;
`endif
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d[lsb +: CHUNK] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = add_co;
                    ovf_d   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                              (add_s[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = StDone;
`ifdef ABS_MODE_EN
                    if (abs_q && add_s[CHUNK-1]) begin
                        state_d = StNeg;
                    end
`endif
                end
            end
`ifdef ABS_MODE_EN
            StNeg: begin
                sum_d[lsb +: CHUNK] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    carry_d = 1'b0;
                    // Only the minimum value stays negative after negation.
                    if (add_s[CHUNK-1]) begin
                        ovf_d = 1'b1;
                    end
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ABS_MODE_EN
            abs_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef ABS_MODE_EN
            abs_q   <= abs_d;
`endif
        end
    end

    assign io.sum  = sum_q;
    assign io.cout = cout_q;
    assign io.ovf  = ovf_q;
    assign io.busy = (state_q != StIdle);
    assign io.done = (state_q == StDone);
endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Scoreboard bench for chunked_addsub_seq (WIDTH=32, CHUNK=16); honours ABS_MODE_EN.
module tb_chunked_addsub_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    chunked_addsub_seq_if #(.WIDTH(32)) bus ();

    chunked_addsub_seq #(
        .WIDTH (32),
        .CHUNK (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned start_cyc;
        int unsigned lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no pending result");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_sum"}, bus.sum, e.sum);
                    check({e.name, "_cout"}, {31'b0, bus.cout}, {31'b0, e.cout});
                    check({e.name, "_ovf"}, {31'b0, bus.ovf}, {31'b0, e.ovf});
                    check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy still high want idle within 50 cycles", nm);
        end
    endtask

    task automatic op(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic abs_req, input logic [31:0] exp_sum,
                      input logic exp_cout, input logic exp_ovf, input int unsigned lat,
                      input bit dup_start);
        exp_t e;
        @(negedge clk);
        wait_idle({nm, "_pre"});
        bus.a       = a;
        bus.b       = b;
        bus.sub     = sub;
        bus.abs_req = abs_req;
        bus.start   = 1'b1;
        e.sum       = exp_sum;
        e.cout      = exp_cout;
        e.ovf       = exp_ovf;
        e.start_cyc = cyc;
        e.lat       = lat;
        e.name      = nm;
        sb.push_back(e);
        @(negedge clk);
        bus.start   = dup_start;
        bus.a       = $urandom;
        bus.b       = $urandom;
        bus.sub     = 1'($urandom);
        bus.abs_req = 1'($urandom);
        check({nm, "_busy"}, {31'b0, bus.busy}, 32'd1);
        if (dup_start) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_idle(nm);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish before 400us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.sub     = 1'b0;
        bus.abs_req = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        repeat (2) @(negedge clk);
        check("reset_sum", bus.sum, 32'd0);
        check("reset_cout", {31'b0, bus.cout}, 32'd0);
        check("reset_ovf", {31'b0, bus.ovf}, 32'd0);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        rst = 1'b0;

        op("carry_chain", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 3, 0);
        op("sub_neg",     32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 3, 0);
`ifdef ABS_MODE_EN
        op("sub_abs",     32'd5, 32'd7, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0, 5, 0);
        op("min_abs",     32'h80000000, 32'd0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 5, 0);
        op("sub_abs2",    32'd3, 32'd10, 1'b1, 1'b1, 32'h00000007, 1'b0, 1'b0, 5, 0);
`else
        op("sub_abs",     32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 3, 0);
        op("min_abs",     32'h80000000, 32'd0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 3, 0);
        op("sub_abs2",    32'd3, 32'd10, 1'b1, 1'b1, 32'hFFFFFFF9, 1'b0, 1'b0, 3, 0);
`endif
        op("pos_ovf",     32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 3, 0);
        op("sub_pos",     32'd7, 32'd5, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 3, 0);
        op("wrap_zero",   32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 3, 0);
        op("neg_ovf",     32'h80000000, 32'd1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 3, 0);
        op("dup_start",   32'h12340000, 32'h00005678, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 3, 1);

        // Abort mid-operation with reset: outputs clear, no done follows.
        @(negedge clk);
        bus.a     = 32'hFFFFFFFF;
        bus.b     = 32'h00000001;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        #1;
        check("abort_sum", bus.sum, 32'd0);
        check("abort_cout", {31'b0, bus.cout}, 32'd0);
        check("abort_ovf", {31'b0, bus.ovf}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        op("after_reset", 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0, 3, 0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_addsub_seq.md
CHUNKED_ADDSUB_SEQ -- requirements
Module: chunked_addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 16, giving the bits processed per cycle.
REQ-003 Elaboration SHALL fail if WIDTH is not an integer multiple of CHUNK; N = WIDTH/CHUNK below.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  request; sampled only in IDLE.
REQ-007 Port sub  input  1  0 = A+B, 1 = A-B; latched with start.
REQ-008 Port abs_req  input  1  1 = return the absolute value of a negative result; latched with start.
REQ-009 Port a  input  WIDTH  operand A; latched with start.
REQ-010 Port b  input  WIDTH  operand B; latched with start.
REQ-011 Port sum  output  WIDTH  registered result.
REQ-012 Port cout  output  1  carry out of the MSB chunk; 1 = no borrow when sub=1.
REQ-013 Port ovf  output  1  signed overflow flag.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle until the next start.

Function
REQ-016 The FSM SHALL have the states IDLE, ADD, NEG and DONE.
REQ-017 IDLE with start=1 SHALL latch a, b, sub and abs_req, clear the chunk index and carry, and go to ADD.
REQ-018 ADD SHALL add one CHUNK slice per cycle, LSB slice first: A + (sub ? ~B : B) + carry.
  - Carry-in to slice 0 = sub.
  - Slice carry is registered into the next cycle.
REQ-019 After slice N-1 of ADD:
  - cout = final slice carry.
  - ovf = signed overflow, i.e. (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the effective operand.
REQ-020 After ADD, the FSM SHALL go to NEG if abs_req=1 and sum MSB=1; otherwise it SHALL go to DONE.
REQ-021 NEG SHALL replace sum with ~sum + 1, one slice per cycle over N cycles, with carry-in 1 to slice 0.
  - cout is unchanged in NEG.
  - If sum was the minimum value (MSB only), the result remains 1000...0 and ovf is set to 1.
REQ-022 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 Latency from the start cycle to the done cycle SHALL be N+1 cycles without NEG and 2N+1 cycles with NEG.
REQ-024 start while busy=1 SHALL be ignored, with no effect on the in-flight operation.
REQ-025 start in the same cycle done is high SHALL be ignored; a new start is accepted in the following IDLE cycle.
REQ-026 Inputs a, b, sub and abs_req SHALL have no effect after the start cycle.

Reset
REQ-027 Asserting rst SHALL immediately force the FSM to IDLE and clear the following:
  - sum = 0, cout = 0, ovf = 0, busy = 0, done = 0.
  - the chunk index and the internal carry.
REQ-028 Reset asserted mid-operation SHALL abort the operation; no done pulse follows.

Configuration
REQ-029 Macro ABS_MODE_EN defined SHALL compile in the NEG state and the abs_req behaviour.
REQ-030 Macro ABS_MODE_EN undefined SHALL remove NEG:
  - abs_req is ignored.
  - latency is always N+1.

Structure
REQ-031 Package addsub_pkg SHALL hold the FSM state enum and the default WIDTH/CHUNK constants.
REQ-032 Sub-module chunk_adder SHALL be a parametrised CHUNK-bit combinational ripple adder (a, b, cin -> s, cout).
  - It is instantiated once and shared by ADD and NEG.

Verification (WIDTH=32, CHUNK=16, N=2)
REQ-033 a=0x0000FFFF, b=0x00000001, sub=0 -> sum=0x00010000, cout=0, ovf=0, done 3 cycles after start.
REQ-034 a=5, b=7, sub=1, abs_req=0 -> sum=0xFFFFFFFE, cout=0, ovf=0, done at +3.
REQ-035 a=5, b=7, sub=1, abs_req=1 with ABS_MODE_EN defined -> sum=0x00000002, done at +5.
  - Same stimulus without ABS_MODE_EN -> sum=0xFFFFFFFE at +3.
REQ-036 a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0.
  - a=0x80000000, b=0, abs_req=1 -> sum=0x80000000, ovf=1.
REQ-037 Second start pulsed at +1 during an operation -> ignored, with the first result unchanged.
  - rst pulsed at +1 -> all outputs 0, no done pulse, and a next start works normally.
